// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} mem_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

  // Transaction captured at issue and replayed while waiting for the bus.
  typedef struct packed {
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic [2:0]            funct3;
  } mem_req_t;

  // Unused funct3 codes fall back to a full-word access.
  function automatic mem_size_e access_size(input logic [2:0] f3, input logic is_store);
    mem_size_e sz;
    sz = SZ_W;
    if (is_store) begin
      case (f3)
        F3_B:    sz = SZ_B;
        F3_H:    sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus: req/gnt request phase, rvalid/rdata response phase.
interface mem_access_unit_if;
  logic                                    req;
  logic                                    we;
  logic [mem_access_unit_pkg::DATA_WIDTH-1:0] addr;
  logic [3:0]                              be;
  logic [mem_access_unit_pkg::DATA_WIDTH-1:0] wdata;
  logic                                    gnt;
  logic                                    rvalid;
  logic [mem_access_unit_pkg::DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            off_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues bus accesses and stalls the pipe until done.
// Optional MEM_TIMEOUT_EN adds a REQ+RESP watchdog that raises bus_err_o.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MEM_MemRead_i,
  input  logic                  MEM_MemWrite_i,
  input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
  input  logic [DATA_WIDTH-1:0] MEM_instruction_i,
  mem_access_unit_if.master     dmem,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  stall_o,
  output logic                  misaligned_o,
  output logic                  bus_err_o
);

  mem_state_e            state_q, state_d;
  mem_req_t              req_q, req_d, issue;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d, ext_data;
  logic [2:0]            funct3;
  logic [1:0]            off;
  mem_size_e             size;
  logic                  op_valid, aligned, timeout;

  assign funct3   = MEM_instruction_i[14:12];
  assign off      = MEM_alu_result_i[1:0];
  assign op_valid = MEM_MemRead_i | MEM_MemWrite_i;
  assign size     = access_size(funct3, MEM_MemWrite_i);

  logic unused_instr;
  assign unused_instr = ^{MEM_instruction_i[31:15], MEM_instruction_i[11:0]};

  always_comb begin
    case (size)
      SZ_H:    aligned = ~off[0];
      SZ_W:    aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Store lane formatting from the live EX/MEM values.
  always_comb begin
    issue        = '0;
    issue.we     = MEM_MemWrite_i;
    issue.addr   = MEM_alu_result_i;
    issue.funct3 = funct3;
    issue.be     = 4'hF;
    issue.wdata  = MEM_wr_data_i;
    if (MEM_MemWrite_i) begin
      case (size)
        SZ_B: begin
          issue.be    = 4'b0001 << off;
          issue.wdata = {4{MEM_wr_data_i[7:0]}};
        end
        SZ_H: begin
          issue.be    = 4'b0011 << {off[1], 1'b0};
          issue.wdata = {2{MEM_wr_data_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata_i  (dmem.rdata),
    .off_i    (req_q.addr[1:0]),
    .funct3_i (req_q.funct3),
    .data_o   (ext_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             busy_q, busy_d;

  assign busy_q  = (state_q == REQ) || (state_q == RESP);
  assign busy_d  = (state_d == REQ) || (state_d == RESP);
  assign timeout = busy_q && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Counts total cycles spent waiting; cleared whenever the wait ends.
  always_comb begin
    tmo_cnt_d = '0;
    if (busy_q && busy_d) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    load_data_d  = load_data_q;
    dmem.req     = 1'b0;
    dmem.we      = req_q.we;
    dmem.addr    = {req_q.addr[DATA_WIDTH-1:2], 2'b00};
    dmem.be      = req_q.be;
    dmem.wdata   = req_q.wdata;
    misaligned_o = 1'b0;
    bus_err_o    = timeout;
    stall_o      = op_valid & aligned & (state_q != DONE);

    case (state_q)
      IDLE: begin
        dmem.we    = issue.we;
        dmem.addr  = {issue.addr[DATA_WIDTH-1:2], 2'b00};
        dmem.be    = issue.be;
        dmem.wdata = issue.wdata;
        if (op_valid) begin
          if (!aligned) begin
            misaligned_o = 1'b1;
          end else begin
            dmem.req = 1'b1;
            req_d    = issue;
            if (dmem.gnt) state_d = issue.we ? DONE : RESP;
            else          state_d = REQ;
          end
        end
      end
      REQ: begin
        if (timeout) begin
          load_data_d = '0;
          state_d     = DONE;
        end else begin
          dmem.req = 1'b1;
          if (dmem.gnt) state_d = req_q.we ? DONE : RESP;
        end
      end
      RESP: begin
        if (timeout) begin
          load_data_d = '0;
          state_d     = DONE;
        end else if (dmem.rvalid) begin
          load_data_d = ext_data;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Reset drops the request and releases the pipe immediately.
    if (!rst_n) begin
      dmem.req     = 1'b0;
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      bus_err_o    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      load_data_q <= load_data_d;
    end
  end

  assign load_data_o = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven plus randomized bench for mem_access_unit with a bus responder.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd, wr;
  logic [31:0] alu, rs2, instr;
  logic [31:0] load_data;
  logic        stall, mis, berr;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .MEM_MemRead_i     (rd),
    .MEM_MemWrite_i    (wr),
    .MEM_alu_result_i  (alu),
    .MEM_wr_data_i     (rs2),
    .MEM_instruction_i (instr),
    .dmem              (bus),
    .load_data_o       (load_data),
    .stall_o           (stall),
    .misaligned_o      (mis),
    .bus_err_o         (berr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_load = 32'h0;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          g, r;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] exp_wdata, exp_load;
    int          stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r_, w_, input logic [2:0] f3, input logic [31:0] a, wd, rdat,
                              input int g, r, input logic m, input logic [3:0] be,
                              input logic [31:0] ew, el, input int st);
    vec_t v;
    v.rd = r_; v.wr = w_; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
    v.g = g; v.r = r; v.mis = m; v.be = be; v.exp_wdata = ew; v.exp_load = el; v.stall = st;
    return v;
  endfunction

  function automatic int msize(input logic [2:0] f3, input logic st);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  // Reference: access size, lane arithmetic and timing from the access rules.
  function automatic vec_t model(input logic r_, w_, input logic [2:0] f3, input logic [31:0] a, wd, rdat,
                                 input int g, r);
    vec_t        v;
    int          sz, lane;
    logic [31:0] sh, mask, val;
    v = mk(r_, w_, f3, a, wd, rdat, g, r, 1'b0, 4'hF, wd, 32'h0, 0);
    sz   = msize(f3, w_);
    lane = int'(a % 4);
    v.mis = (a % sz) != 0;
    if (w_) v.be = 4'(((1 << sz) - 1) << lane);
    if (sz == 1)      v.exp_wdata = {24'h0, wd[7:0]} * 32'h01010101;
    else if (sz == 2) v.exp_wdata = {16'h0, wd[15:0]} * 32'h00010001;
    sh   = rdat >> (8 * lane);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    val  = sh & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && sz < 4 && val[8*sz-1]) val = val | ~mask;
    v.exp_load = val;
    v.stall = v.mis ? 0 : (r_ ? g + r + 1 : g + 1);
    return v;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    rd = 0; wr = 0; bus.gnt = 0; bus.rvalid = 0;
    @(negedge clk);
    chk("idle stall", {31'h0, stall}, 32'h0);
    chk("idle req", {31'h0, bus.req}, 32'h0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    bit          done;
    int          scnt;
    logic [31:0] tmp;
    done = 0; scnt = 0;
    @(posedge clk); #1;
    tmp   = $urandom;
    rd    = v.rd; wr = v.wr; alu = v.addr; rs2 = v.wdata;
    instr = (tmp & 32'hFFFF_8FFF) | ({29'h0, v.f3} << 12);
    if (v.mis) begin
      bus.gnt = 1; bus.rvalid = 1; bus.rdata = $urandom;
      @(negedge clk);
      chk({tag, " misaligned"}, {31'h0, mis}, 32'h1);
      chk({tag, " mis req"}, {31'h0, bus.req}, 32'h0);
      chk({tag, " mis stall"}, {31'h0, stall}, 32'h0);
      chk({tag, " mis load_data"}, load_data, last_load);
    end else begin
      for (int c = 0; c < 40; c++) begin
        bus.gnt    = (c == v.g);
        bus.rvalid = v.rd && (c == v.g + v.r);
        bus.rdata  = bus.rvalid ? v.rdata : $urandom;
        @(negedge clk);
        if (c == 0) chk({tag, " no mis"}, {31'h0, mis}, 32'h0);
        chk({tag, " bus_err"}, {31'h0, berr}, 32'h0);
        if (c <= v.g) begin
          chk({tag, " req"}, {31'h0, bus.req}, 32'h1);
          chk({tag, " we"}, {31'h0, bus.we}, {31'h0, v.wr});
          chk({tag, " addr"}, bus.addr, v.addr & 32'hFFFF_FFFC);
          chk({tag, " be"}, {28'h0, bus.be}, {28'h0, v.be});
          if (v.wr) chk({tag, " wdata"}, bus.wdata, v.exp_wdata);
        end else begin
          chk({tag, " req low"}, {31'h0, bus.req}, 32'h0);
        end
        if (!stall) begin
          done = 1;
          break;
        end
        scnt++;
        @(posedge clk); #1;
      end
      if (!done) chk({tag, " completion"}, 32'h0, 32'h1);
      chk({tag, " stall cycles"}, 32'(scnt), 32'(v.stall));
      if (v.rd) last_load = v.exp_load;
      chk({tag, " load_data"}, load_data, last_load);
    end
    idle();
  endtask

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rd = 0; wr = 0; alu = 32'h100; rs2 = 0; instr = 32'h0000_2003;
    bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;

    // Reset state, with a live load held on the inputs.
    rd = 1;
    #3;
    chk("reset req", {31'h0, bus.req}, 32'h0);
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset mis", {31'h0, mis}, 32'h0);
    chk("reset bus_err", {31'h0, berr}, 32'h0);
    chk("reset load_data", load_data, 32'h0);
    rd = 0;
    #10 rst_n = 1;

    tbl[0]  = mk(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 0, 4'hF, 32'hDEADBEEF, 0, 1);
    tbl[1]  = mk(0, 1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0, 1, 0, 4'h8, 32'hA5A5A5A5, 0, 1);
    tbl[2]  = mk(1, 0, 3'd0, 32'h102, 32'h0, 32'h12F03456, 2, 1, 0, 4'hF, 0, 32'hFFFFFFF0, 4);
    tbl[3]  = mk(1, 0, 3'd4, 32'h102, 32'h0, 32'h12F03456, 2, 1, 0, 4'hF, 0, 32'h000000F0, 4);
    tbl[4]  = mk(0, 1, 3'd1, 32'h102, 32'h1234BEEF, 32'h0, 1, 1, 0, 4'hC, 32'hBEEFBEEF, 0, 2);
    tbl[5]  = mk(1, 0, 3'd1, 32'h102, 32'h0, 32'h80017FFF, 0, 1, 0, 4'hF, 0, 32'hFFFF8001, 2);
    tbl[6]  = mk(1, 0, 3'd5, 32'h100, 32'h0, 32'h8001F00F, 1, 2, 0, 4'hF, 0, 32'h0000F00F, 4);
    tbl[7]  = mk(1, 0, 3'd2, 32'h104, 32'h0, 32'hCAFEBABE, 0, 2, 0, 4'hF, 0, 32'hCAFEBABE, 3);
    tbl[8]  = mk(1, 0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 1, 1, 4'hF, 0, 0, 0);
    tbl[9]  = mk(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1, 1, 4'hF, 0, 0, 0);
    tbl[10] = mk(0, 1, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1, 1, 4'hF, 0, 0, 0);
    tbl[11] = mk(1, 0, 3'd0, 32'h003, 32'h0, 32'h7F000000, 0, 1, 0, 4'hF, 0, 32'h0000007F, 2);

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Stray gnt/rvalid with nothing issued must not disturb the result.
    @(posedge clk); #1;
    bus.gnt = 1; bus.rvalid = 1; bus.rdata = 32'h5555_5555;
    @(negedge clk);
    chk("stray req", {31'h0, bus.req}, 32'h0);
    @(posedge clk); #1;
    bus.gnt = 0; bus.rvalid = 0;
    @(negedge clk);
    chk("stray load_data", load_data, last_load);

    // Reset while waiting in RESP; a late rvalid must be dropped.
    @(posedge clk); #1;
    rd = 1; wr = 0; alu = 32'h200; instr = 32'h0000_2003; bus.gnt = 1;
    @(negedge clk);
    chk("rst issue req", {31'h0, bus.req}, 32'h1);
    @(posedge clk); #1;
    bus.gnt = 0;
    @(negedge clk);
    chk("rst resp req", {31'h0, bus.req}, 32'h0);
    chk("rst resp stall", {31'h0, stall}, 32'h1);
    #2 rst_n = 0;
    #1;
    chk("rst mid req", {31'h0, bus.req}, 32'h0);
    chk("rst mid stall", {31'h0, stall}, 32'h0);
    chk("rst mid load_data", load_data, 32'h0);
    @(posedge clk); #1;
    rd = 0; rst_n = 1;
    bus.rvalid = 1; bus.rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late rvalid load_data", load_data, 32'h0);
    chk("late rvalid stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    bus.rvalid = 0;
    @(negedge clk);
    chk("post rst load_data", load_data, 32'h0);
    last_load = 32'h0;

    for (int i = 0; i < 40; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          pick;
      st   = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, st ? 2 : 4);
      case (pick)
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      a = $urandom;
      apply(model(~st, st, f3, a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(1, 2)),
            $sformatf("rnd%0d", i));
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int err_c, err_n, end_c;
      err_c = -1; err_n = 0; end_c = -1;
      @(posedge clk); #1;
      rd = 1; wr = 0; alu = 32'h300; instr = 32'h0000_2003; bus.gnt = 0; bus.rvalid = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (berr) begin
          err_n++;
          if (err_c < 0) err_c = c;
          chk("tmo req dropped", {31'h0, bus.req}, 32'h0);
        end
        if (!stall) begin
          end_c = c;
          break;
        end
        @(posedge clk); #1;
      end
      chk("tmo bus_err cycle", 32'(err_c), 32'd5);
      chk("tmo bus_err width", 32'(err_n), 32'd1);
      chk("tmo stall release", 32'(end_c), 32'd6);
      chk("tmo load_data", load_data, 32'h0);
      last_load = 32'h0;
      idle();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
